pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register; generic successor to the fixed-width stage registers between IF/ID/EX/MEM/WB.
- Carries one control bundle, one data payload, PC and instruction per beat.
- Adds valid/ready flow control, an optional 2-entry skid buffer for full throughput under backpressure, and synchronous flush with NOP/bubble insertion.
- Every stage boundary of the pipelined core instantiates it.

Parameters:
- CTRL_W, 3: width of control bundle (e.g. WB write-enable/select bits); all-zero means no side effects.
- DATA_W, 256: width of concatenated payload (data_in, alu_result, imm, rd_addr, ...).
- PC_W, 32: width of each PC field.
- INST_W, 32: instruction width.
- NOP_INST, 32'h00000013: instruction value presented for bubbles (addi x0,x0,0).
- SKID, 1: 1 = two entries with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  payload.
- in_pc  in  PC_W  instruction PC.
- in_pc_next  in  PC_W  PC+4 / link value.
- in_inst  in  INST_W  instruction word.
- out_valid  out  1  main entry holds a live beat.
- out_ready  in  1  downstream consumes the beat.
- out_ctrl  out  CTRL_W  control; forced 0 when out_valid=0.
- out_data  out  DATA_W  payload.
- out_pc  out  PC_W  PC.
- out_pc_next  out  PC_W  PC+4 / link value.
- out_inst  out  INST_W  instruction; forced NOP_INST when out_valid=0.
- occupancy  out  2  live entries held (0..2; max 1 when SKID=0).

Behaviour:
- Storage: main entry M (drives out_*) and, if SKID=1, skid entry S; each has a valid bit and fields ctrl/data/pc/pc_next/inst.
- fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- Reset (async):
  - M.valid=0 and S.valid=0.
  - All stored fields 0, inst fields NOP_INST.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, out_pc=0, out_pc_next=0, out_inst=NOP_INST, occupancy=0, in_ready=1.
- Priority each clock edge: rst > flush > normal.
- Flush:
  - Next cycle M.valid=0 and S.valid=0.
  - Any beat firing this cycle is discarded (counts as consumed upstream).
  - Data/pc fields hold their old values.
  - Outputs show a bubble: out_ctrl=0, out_inst=NOP_INST.
- SKID=1, normal operation:
  - If M empty or fire_out: M loads S if S.valid, else the input beat if fire_in, else M.valid becomes 0. S is then loaded with the input beat if S was valid and fire_in, otherwise S clears.
  - If M full and no fire_out: a fire_in beat goes to S.
  - in_ready = !S.valid, registered (no combinational path from out_ready).
  - Because in_ready=0 whenever S is full, a beat can never arrive while both entries are full.
- SKID=0, normal operation:
  - in_ready = !M.valid | out_ready (combinational).
  - M loads on fire_in; otherwise fire_out clears M.valid.
- Timing: latency 1 cycle from fire_in to out_valid; sustained throughput 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO order; no beat is duplicated or dropped except by flush.
- While out_valid=0: out_data/out_pc/out_pc_next hold the last loaded values. Consumers must qualify them with out_valid; the bench does not check them.
- Stability rule: while out_valid=1 and out_ready=0, every out_* field is stable.
- occupancy = M.valid + S.valid.
- Reset mid-transfer: entries are lost immediately, with no partial state.

Decomposition:
- Shared package pipe_pkg:
  - constant NOP_INST (32'h00000013).
  - CTRL_BUBBLE = '0.
  - Per-stage payload struct typedefs (ex_mem_t, mem_wb_t) with their widths, used for DATA_W at instantiation.
- One sub-module, pipe_slot: a single entry register with load, clear and field storage plus valid bit. It is instantiated as M and, when SKID=1, as S.

Test Plan:
- Reset with in_valid=1 and pc=0x100 → out_valid=0, out_inst=0x00000013, out_ctrl=0, in_ready=1, occupancy=0; after release, the beat is accepted and the next cycle out_pc=0x100.
- Stream of 4 beats (pc 0x0, 0x4, 0x8, 0xC) with out_ready=1 → outputs appear one per cycle, 1-cycle latency, same order, occupancy stays 1.
- SKID=1, out_ready=0 while 3 beats are offered → M=0x0, S=0x4, in_ready=0 after the 2nd beat, 3rd beat held upstream. Raising out_ready then delivers 0x0, 0x4, 0x8 back-to-back with no gaps.
- Both entries full plus in_valid=1 and flush=1 → next cycle out_valid=0, occupancy=0, out_inst=0x00000013, out_ctrl=0, in_ready=1; no flushed PC ever appears at the output.
- SKID=0, out_valid=1, out_ready toggles → in_ready follows out_ready in the same cycle; a beat is accepted and the old one replaced on each cycle both are high.
- Async rst asserted mid-cycle with occupancy=2 → outputs go to reset values before the next clk edge; the first beat after release passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers: the bubble encodings
// and the per-stage payload layouts that set DATA_W at each boundary.
package pipe_pkg;

  // Instruction shown for a bubble: addi x0, x0, 0.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // A bubble carries an all-zero control bundle, meaning no side effects.
  // Stored as one bit and replicated to whatever CTRL_W a stage uses.
  localparam logic CTRL_BUBBLE = 1'b0;

  // EX/MEM payload: everything the memory stage needs from execute.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
  } ex_mem_t;

  // MEM/WB payload: the value to write back and where it goes.
  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd_addr;
  } mem_wb_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline-stage register: a valid bit plus the
// ctrl/data/pc/pc_next/inst fields. Clear beats load so a kill is never
// undone by a beat arriving in the same cycle.
module pipe_slot #(
  parameter int                CTRL_W   = 3,
  parameter int                DATA_W   = 256,
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_pkg::NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [PC_W-1:0]   i_pc_next,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc,
  output logic [PC_W-1:0]   o_pc_next,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pc_next;
  logic [INST_W-1:0] r_inst;

  // Valid bit: set on load, dropped on clear; clear has the last word.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // Payload fields: captured on an accepted load, otherwise held (a clear
  // leaves the old contents in place; consumers qualify them with valid).
  // NOTE: the payload is reset as well as the valid bit so every output is
  // defined straight out of reset, including the NOP instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_data    <= '0;
      r_pc      <= '0;
      r_pc_next <= '0;
      r_inst    <= NOP_INST;
    end else if (i_load && !i_clear) begin
      r_ctrl    <= i_ctrl;
      r_data    <= i_data;
      r_pc      <= i_pc;
      r_pc_next <= i_pc_next;
      r_inst    <= i_inst;
    end
  end

  assign o_valid   = r_valid;
  assign o_ctrl    = r_ctrl;
  assign o_data    = r_data;
  assign o_pc      = r_pc;
  assign o_pc_next = r_pc_next;
  assign o_inst    = r_inst;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register placed at every stage boundary.
// Main entry M drives the outputs; with SKID=1 a second entry S absorbs the
// beat that arrives while M is stalled, so in_ready can be a plain flop
// (no combinational path from out_ready) and throughput stays at 1 beat/cycle.
// With SKID=0 there is only M and in_ready is combinational.
// flush kills everything held and anything arriving in the same cycle.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 3,
  parameter int                DATA_W   = 256,
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_pkg::NOP_INST),
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_pc_next,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc_next,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  logic w_fire_in;
  logic w_fire_out;
  logic w_m_adv;
  logic w_m_load;
  logic w_m_clear;
  logic w_s_load;
  logic w_s_clear;

  // Main entry
  logic              w_m_valid;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic [DATA_W-1:0] w_m_data;
  logic [PC_W-1:0]   w_m_pc;
  logic [PC_W-1:0]   w_m_pc_next;
  logic [INST_W-1:0] w_m_inst;

  // Skid entry (tied off when SKID=0)
  logic              w_s_valid;
  logic [CTRL_W-1:0] w_s_ctrl;
  logic [DATA_W-1:0] w_s_data;
  logic [PC_W-1:0]   w_s_pc;
  logic [PC_W-1:0]   w_s_pc_next;
  logic [INST_W-1:0] w_s_inst;

  // What M loads: the older beat in S when there is one, else the input.
  logic [CTRL_W-1:0] w_md_ctrl;
  logic [DATA_W-1:0] w_md_data;
  logic [PC_W-1:0]   w_md_pc;
  logic [PC_W-1:0]   w_md_pc_next;
  logic [INST_W-1:0] w_md_inst;

  // With SKID=1 in_ready is just the inverted S valid flop.
  assign in_ready   = SKID ? !w_s_valid : (!w_m_valid || out_ready);
  assign w_fire_in  = in_valid && in_ready;
  assign w_fire_out = w_m_valid && out_ready;
  assign w_m_adv    = !w_m_valid || w_fire_out;

  assign w_md_ctrl    = w_s_valid ? w_s_ctrl    : in_ctrl;
  assign w_md_data    = w_s_valid ? w_s_data    : in_data;
  assign w_md_pc      = w_s_valid ? w_s_pc      : in_pc;
  assign w_md_pc_next = w_s_valid ? w_s_pc_next : in_pc_next;
  assign w_md_inst    = w_s_valid ? w_s_inst    : in_inst;

  // Entry control: flush overrides everything; otherwise keep FIFO order by
  // always refilling M from S before taking a new beat.
  // NOTE: every signal gets a default first so no path through the block
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    w_m_load  = 1'b0;
    w_m_clear = 1'b0;
    w_s_load  = 1'b0;
    w_s_clear = 1'b0;
    if (flush) begin
      w_m_clear = 1'b1;
      w_s_clear = 1'b1;
    end else if (SKID) begin
      if (w_m_adv) begin
        w_m_load  = w_s_valid || w_fire_in;
        w_m_clear = !(w_s_valid || w_fire_in);
        w_s_load  = w_s_valid && w_fire_in;
        w_s_clear = !(w_s_valid && w_fire_in);
      end else begin
        w_s_load  = w_fire_in;
      end
    end else begin
      w_m_load  = w_fire_in;
      w_m_clear = w_fire_out && !w_fire_in;
    end
  end

  pipe_slot #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP_INST)
  ) u_m (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_m_load),
    .i_clear   (w_m_clear),
    .i_ctrl    (w_md_ctrl),
    .i_data    (w_md_data),
    .i_pc      (w_md_pc),
    .i_pc_next (w_md_pc_next),
    .i_inst    (w_md_inst),
    .o_valid   (w_m_valid),
    .o_ctrl    (w_m_ctrl),
    .o_data    (w_m_data),
    .o_pc      (w_m_pc),
    .o_pc_next (w_m_pc_next),
    .o_inst    (w_m_inst)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .CTRL_W   (CTRL_W),
      .DATA_W   (DATA_W),
      .PC_W     (PC_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP_INST)
    ) u_s (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_s_load),
      .i_clear   (w_s_clear),
      .i_ctrl    (in_ctrl),
      .i_data    (in_data),
      .i_pc      (in_pc),
      .i_pc_next (in_pc_next),
      .i_inst    (in_inst),
      .o_valid   (w_s_valid),
      .o_ctrl    (w_s_ctrl),
      .o_data    (w_s_data),
      .o_pc      (w_s_pc),
      .o_pc_next (w_s_pc_next),
      .o_inst    (w_s_inst)
    );
  end else begin : g_no_skid
    assign w_s_valid   = 1'b0;
    assign w_s_ctrl    = '0;
    assign w_s_data    = '0;
    assign w_s_pc      = '0;
    assign w_s_pc_next = '0;
    assign w_s_inst    = NOP_INST;
  end

  // Bubbles present an inert control bundle and a NOP; data/pc simply hold.
  assign out_valid   = w_m_valid;
  assign out_ctrl    = w_m_valid ? w_m_ctrl : {CTRL_W{CTRL_BUBBLE}};
  assign out_inst    = w_m_valid ? w_m_inst : NOP_INST;
  assign out_data    = w_m_data;
  assign out_pc      = w_m_pc;
  assign out_pc_next = w_m_pc_next;
  assign occupancy   = {1'b0, w_m_valid} + {1'b0, w_s_valid};

endmodule
